// File: rtl/flip_flop_fifo_status_flags.sv
// Flip-flop FIFO of arbitrary depth with occupancy count, programmable
// almost-full/almost-empty flags and sticky overflow/underflow error flags.
module flip_flop_fifo_status_flags #(
  parameter int width              = 8,
  parameter int depth              = 10,
  parameter int almost_full_level  = depth - 2,
  parameter int almost_empty_level = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           write_data,
  input  logic                       clear_errors,
  output logic [width-1:0]           read_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = $clog2(depth + 1);

  typedef logic [ptr_w-1:0] ptr_t;
  typedef logic [cnt_w-1:0] cnt_t;

  localparam ptr_t last_idx = ptr_t'(depth - 1);
  localparam cnt_t af_level = cnt_t'(almost_full_level);
  localparam cnt_t ae_level = cnt_t'(almost_empty_level);

  logic [width-1:0] mem [depth];
  ptr_t             wr_ptr, rd_ptr;
  logic             wr_par, rd_par;
  cnt_t             count_q;
  logic             push_ok, pop_ok;

  // Flags decode straight from the pointer registers; parity separates full from empty.
  assign empty        = (wr_ptr == rd_ptr) && (wr_par == rd_par);
  assign full         = (wr_ptr == rd_ptr) && (wr_par != rd_par);
  assign count        = count_q;
  assign almost_full  = (count_q >= af_level);
  assign almost_empty = (count_q <= ae_level);
  assign read_data    = mem[rd_ptr];

  // Accept decisions use pre-edge state; a full FIFO still takes a push paired with a pop.
  always_comb begin
    push_ok = push && (!full || pop);
    pop_ok  = pop && !empty;
  end

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= write_data;
  end

  // Pointer advance with wrap at depth-1 and parity toggle on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wr_par <= 1'b0;
      rd_par <= 1'b0;
    end else begin
      if (push_ok) begin
        if (wr_ptr == last_idx) begin
          wr_ptr <= '0;
          wr_par <= ~wr_par;
        end else begin
          wr_ptr <= wr_ptr + ptr_t'(1);
        end
      end
      if (pop_ok) begin
        if (rd_ptr == last_idx) begin
          rd_ptr <= '0;
          rd_par <= ~rd_par;
        end else begin
          rd_ptr <= rd_ptr + ptr_t'(1);
        end
      end
    end
  end

  // Occupancy count: moves only when exactly one side is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new error event takes priority over clear_errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !push_ok)  overflow <= 1'b1;
      else if (clear_errors) overflow <= 1'b0;
      if (pop && !pop_ok)    underflow <= 1'b1;
      else if (clear_errors) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flip_flop_fifo_status_flags.sv
// Self-checking bench: two FIFOs (depth 5 and depth 10) driven in lockstep,
// checked against a queue-based reference model, a vector table and directed sequences.
module tb_flip_flop_fifo_status_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] write_data = '0;

  logic [7:0] rd_a, rd_b;
  logic       empty_a, full_a, ae_a, af_a, ov_a, un_a;
  logic       empty_b, full_b, ae_b, af_b, ov_b, un_b;
  logic [2:0] cnt_a;
  logic [3:0] cnt_b;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit ova = 0, una = 0, ovb = 0, unb = 0;

  always #5 clk = ~clk;

  flip_flop_fifo_status_flags #(.width(8), .depth(5), .almost_full_level(3), .almost_empty_level(2)) dut_a (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .write_data(write_data),
    .clear_errors(clear_errors), .read_data(rd_a), .empty(empty_a), .full(full_a),
    .almost_empty(ae_a), .almost_full(af_a), .count(cnt_a), .overflow(ov_a), .underflow(un_a)
  );

  flip_flop_fifo_status_flags #(.width(8), .depth(10), .almost_full_level(8), .almost_empty_level(2)) dut_b (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .write_data(write_data),
    .clear_errors(clear_errors), .read_data(rd_b), .empty(empty_b), .full(full_b),
    .almost_empty(ae_b), .almost_full(af_b), .count(cnt_b), .overflow(ov_b), .underflow(un_b)
  );

  typedef struct {
    bit         r, p, o, c;
    logic [7:0] d;
    int         ecnt;
    bit         eempty, efull, eov, eun;
    logic [7:0] erd;
  } vec_t;

  vec_t tbl[25];

  task automatic cmp(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic upd(input int d, inout logic [7:0] q[$], inout bit ov, inout bit un,
                     input bit r, input bit p, input bit o, input bit c, input logic [7:0] wd);
    bit pa, po;
    if (r) begin
      q.delete();
      ov = 0;
      un = 0;
    end else begin
      pa = p && ((q.size() < d) || o);
      po = o && (q.size() > 0);
      if (po) void'(q.pop_front());
      if (pa) q.push_back(wd);
      if (p && !pa) ov = 1; else if (c) ov = 0;
      if (o && !po) un = 1; else if (c) un = 0;
    end
  endtask

  task automatic check_model();
    cmp("a_count", int'(cnt_a), qa.size());
    cmp("a_empty", int'(empty_a), int'(qa.size() == 0));
    cmp("a_full", int'(full_a), int'(qa.size() == 5));
    cmp("a_almost_full", int'(af_a), int'(qa.size() >= 3));
    cmp("a_almost_empty", int'(ae_a), int'(qa.size() <= 2));
    cmp("a_overflow", int'(ov_a), int'(ova));
    cmp("a_underflow", int'(un_a), int'(una));
    if (qa.size() > 0) cmp("a_read_data", int'(rd_a), int'(qa[0]));
    cmp("b_count", int'(cnt_b), qb.size());
    cmp("b_empty", int'(empty_b), int'(qb.size() == 0));
    cmp("b_full", int'(full_b), int'(qb.size() == 10));
    cmp("b_almost_full", int'(af_b), int'(qb.size() >= 8));
    cmp("b_almost_empty", int'(ae_b), int'(qb.size() <= 2));
    cmp("b_overflow", int'(ov_b), int'(ovb));
    cmp("b_underflow", int'(un_b), int'(unb));
    if (qb.size() > 0) cmp("b_read_data", int'(rd_b), int'(qb[0]));
  endtask

  task automatic step(input bit r, input bit p, input bit o, input bit c, input logic [7:0] d);
    @(negedge clk);
    rst = r; push = p; pop = o; clear_errors = c; write_data = d;
    @(posedge clk);
    upd(5, qa, ova, una, r, p, o, c, d);
    upd(10, qb, ovb, unb, r, p, o, c, d);
    #1;
    check_model();
  endtask

  function automatic vec_t mk(bit r, bit p, bit o, bit c, logic [7:0] d, int ecnt,
                              bit ee, bit ef, bit eov, bit eun, logic [7:0] erd);
    vec_t v;
    v.r = r; v.p = p; v.o = o; v.c = c; v.d = d; v.ecnt = ecnt;
    v.eempty = ee; v.efull = ef; v.eov = eov; v.eun = eun; v.erd = erd;
    return v;
  endfunction

  initial begin
    // depth-5 expectations:      r  p  o  c  data   cnt e  f  ov un head
    tbl[0]  = mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00); // reset
    tbl[1]  = mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00); // idle
    tbl[2]  = mk(0, 1, 0, 0, 8'h11, 1, 0, 0, 0, 0, 8'h11);
    tbl[3]  = mk(0, 1, 0, 0, 8'h12, 2, 0, 0, 0, 0, 8'h11);
    tbl[4]  = mk(0, 1, 0, 0, 8'h13, 3, 0, 0, 0, 0, 8'h11);
    tbl[5]  = mk(0, 1, 0, 0, 8'h14, 4, 0, 0, 0, 0, 8'h11);
    tbl[6]  = mk(0, 1, 0, 0, 8'h15, 5, 0, 1, 0, 0, 8'h11);
    tbl[7]  = mk(0, 1, 0, 0, 8'h99, 5, 0, 1, 1, 0, 8'h11); // rejected push
    tbl[8]  = mk(0, 1, 1, 0, 8'hAA, 5, 0, 1, 1, 0, 8'h12); // push+pop while full
    tbl[9]  = mk(0, 0, 0, 1, 8'h00, 5, 0, 1, 0, 0, 8'h12); // clear
    tbl[10] = mk(0, 0, 1, 0, 8'h00, 4, 0, 0, 0, 0, 8'h13);
    tbl[11] = mk(0, 0, 1, 0, 8'h00, 3, 0, 0, 0, 0, 8'h14);
    tbl[12] = mk(0, 0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 8'h15);
    tbl[13] = mk(0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 0, 8'hAA);
    tbl[14] = mk(0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
    tbl[15] = mk(0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 8'h00); // pop when empty
    tbl[16] = mk(0, 1, 1, 0, 8'h3C, 1, 0, 0, 0, 1, 8'h3C); // push+pop while empty
    tbl[17] = mk(0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 8'h00);
    tbl[18] = mk(0, 0, 1, 1, 8'h00, 0, 1, 0, 0, 1, 8'h00); // error beats clear
    tbl[19] = mk(0, 0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 8'h00);
    tbl[20] = mk(0, 1, 0, 0, 8'h01, 1, 0, 0, 0, 0, 8'h01);
    tbl[21] = mk(0, 1, 0, 0, 8'h02, 2, 0, 0, 0, 0, 8'h01);
    tbl[22] = mk(0, 1, 0, 0, 8'h03, 3, 0, 0, 0, 0, 8'h01);
    tbl[23] = mk(1, 1, 0, 0, 8'h04, 0, 1, 0, 0, 0, 8'h00); // reset beats push
    tbl[24] = mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].r, tbl[i].p, tbl[i].o, tbl[i].c, tbl[i].d);
      cmp($sformatf("tbl%0d_count", i), int'(cnt_a), tbl[i].ecnt);
      cmp($sformatf("tbl%0d_empty", i), int'(empty_a), int'(tbl[i].eempty));
      cmp($sformatf("tbl%0d_full", i), int'(full_a), int'(tbl[i].efull));
      cmp($sformatf("tbl%0d_overflow", i), int'(ov_a), int'(tbl[i].eov));
      cmp($sformatf("tbl%0d_underflow", i), int'(un_a), int'(tbl[i].eun));
      if (!tbl[i].eempty) cmp($sformatf("tbl%0d_read_data", i), int'(rd_a), int'(tbl[i].erd));
    end

    // Wrap crossing on depth 5: three fill/drain rounds toggle both parities.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        step(0, 1, 0, 0, 8'(8'h11 + i));
        cmp("wrap_count", int'(cnt_a), i + 1);
      end
      cmp("wrap_full", int'(full_a), 1);
      for (int i = 0; i < 5; i++) begin
        cmp("wrap_read_data", int'(rd_a), 8'h11 + i);
        step(0, 0, 1, 0, 8'h00);
      end
      cmp("wrap_empty", int'(empty_a), 1);
    end

    // Almost-flag sweep on depth 10 (levels 8 and 2).
    step(1, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 0, 0, 8'(i));
      cmp("sweep_af_up", int'(af_b), int'(i >= 8));
      cmp("sweep_ae_up", int'(ae_b), int'(i <= 2));
    end
    for (int i = 9; i >= 0; i--) begin
      step(0, 0, 1, 0, 8'h00);
      cmp("sweep_af_dn", int'(af_b), int'(i >= 8));
      cmp("sweep_ae_dn", int'(ae_b), int'(i <= 2));
    end

    // Randomized traffic with alternating push bias to reach both full and empty.
    for (int n = 0; n < 2000; n++) begin
      int bias;
      bit p, o, c, r;
      bias = ((n / 200) % 2 == 0) ? 75 : 30;
      p = ($urandom_range(0, 99) < bias);
      o = ($urandom_range(0, 99) < (100 - bias));
      c = ($urandom_range(0, 99) < 5);
      r = ($urandom_range(0, 999) < 8);
      step(r, p, o, c, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flip_flop_fifo_status_flags.md
Name: flip_flop_fifo_status_flags

Overview:
- Parametrised flip-flop FIFO with arbitrary, non-power-of-two depth.
- Beyond empty/full, it provides:
  - occupancy count
  - programmable almost-full / almost-empty flags
  - sticky overflow / underflow error flags with a clear input
  - defined behaviour for illegal push/pop
- Used as the standard small elastic buffer between pipeline stages, where upstream throttles early on almost_full.

Parameters:
- width, 8, data word width in bits (>= 1).
- depth, 10, number of entries (>= 2, any integer, not limited to powers of two).
- almost_full_level, depth - 2, almost_full asserts when count >= this value (1..depth).
- almost_empty_level, 2, almost_empty asserts when count <= this value (0..depth-1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- push  input  1  write request.
- pop  input  1  read request.
- write_data  input  width  data written on accepted push.
- clear_errors  input  1  clears sticky error flags.
- read_data  output  width  head entry; valid only while empty = 0.
- empty  output  1  count == 0.
- full  output  1  count == depth.
- almost_empty  output  1  count <= almost_empty_level.
- almost_full  output  1  count >= almost_full_level.
- count  output  $clog2(depth+1)  current occupancy, 0..depth.
- overflow  output  1  sticky: a push was rejected.
- underflow  output  1  sticky: a pop was rejected.

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values (state after a posedge with rst = 1):
  - pointers and count = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - overflow = 0, underflow = 0
  - Storage array is not reset; read_data is don't-care while empty.
  - rst overrides push, pop and clear_errors in the same cycle. Reset mid-operation discards all contents.
- Pointers:
  - wr_ptr and rd_ptr each count 0..depth-1 and wrap from depth-1 to 0.
  - Each pointer has a wrap-parity bit that toggles on its wrap.
- Flags from pointers:
  - empty = pointers equal and parity equal.
  - full = pointers equal and parity differs.
  - count is a separate register and must always agree with empty/full.
- Accepted operations, evaluated against state before the edge:
  - push accepted when full = 0, OR when full = 1 and pop = 1.
  - pop accepted when empty = 0.
  - Accepted push writes write_data to data[wr_ptr] and advances wr_ptr.
  - Accepted pop advances rd_ptr.
- Count update:
  - +1 on push only, -1 on pop only.
  - Unchanged when both or neither are accepted.
- Simultaneous events:
  - Full with push & pop: both accepted; count stays depth; full stays 1. The new word lands in the slot just vacated.
  - Empty with push & pop: push accepted, pop rejected (underflow set); count becomes 1.
- Illegal operations:
  - Push when full without pop: data and pointers unchanged; overflow <= 1.
  - Pop when empty: pointers unchanged; underflow <= 1.
- Sticky error flags:
  - overflow and underflow hold until clear_errors = 1 or rst.
  - If clear_errors coincides with a new error event, the new event wins (flag = 1).
- Latency:
  - read_data is combinational from data[rd_ptr].
  - A word pushed into an empty FIFO is visible on read_data, with empty = 0, in the cycle after the push edge.
  - All status outputs are registered or decoded directly from registers; no input-to-output combinational path.
- almost_empty and almost_full are decoded from count. Both may be asserted together when the levels overlap.

Test Plan:
- Reset, then idle -> empty = 1, count = 0, almost_empty = 1, full = 0, overflow = 0, underflow = 0.
- depth = 5: push 0x11..0x15, then pop 5 -> count 1,2,3,4,5; full = 1 after the 5th push; read_data sequence 0x11..0x15; empty = 1 at the end. Repeat 3 times to cross the wrap at index 4 and both parity toggles.
- depth = 5, full: push 0x99 alone -> overflow = 1, count stays 5, head unchanged. Then push 0xAA & pop together -> count 5, head advances, 0xAA read 5th. Then clear_errors -> overflow = 0.
- Empty: push 0x3C & pop together -> count = 1, read_data = 0x3C, underflow = 1. Then pop alone -> empty, and underflow stays 1.
- depth = 10, almost_full_level = 8, almost_empty_level = 2: fill to 10 and drain to 0 -> almost_full is 1 exactly for count >= 8; almost_empty is 1 exactly for count <= 2.
- Fill to count = 3, assert rst with push = 1 -> next cycle count = 0, empty = 1, and the push is discarded.
